// File: rtl/bcd_segment_feeder_pkg.sv
// bcd_segment_feeder_pkg: shared FSM encodings, segment patterns and the double-dabble adjust step
package bcd_segment_feeder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/bcd_segment_feeder_seven_seg_decoder.sv
// seven_seg_decoder: one BCD digit plus blank flag to active-low {g..a} cathodes
module seven_seg_decoder
  import bcd_segment_feeder_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  // digit lookup; 10..15 and blanked digits show nothing
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/bcd_segment_feeder.sv
// bcd_segment_feeder: binary-to-BCD double-dabble converter feeding a multiplexed 7-segment display
module bcd_segment_feeder
  import bcd_segment_feeder_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IN_WIDTH-1:0] din,
  input  logic                load,
  input  logic                blank_en,
  input  logic [1:0]          dspl,
  output logic                busy,
  output logic                done,
  output logic [15:0]         bcd,
  output logic [6:0]          seg,
  output logic                dp
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  state_t state, state_nx;
  logic [IN_WIDTH-1:0] sr;
  logic [15:0] scratch, adj, upper;
  logic [CW-1:0] cnt;
  logic accept, last, blank;
  assign adj = dabble_adjust(scratch);
  assign accept = (state == IDLE) && load && !done;
  assign last = cnt == CW'(IN_WIDTH - 1);
  assign busy = state != IDLE;
  assign dp = 1'b1;
  // next state: IN_WIDTH shift cycles, then one commit cycle
  always_comb begin
    state_nx = (state == IDLE) ? (accept ? CONVERT : IDLE) :
               (state == CONVERT) ? (last ? COMMIT : CONVERT) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= clr ? IDLE : state_nx;
  end
  // conversion datapath and committed display register
  always_ff @(posedge clk) begin
    if (clr) begin
      {sr, scratch, cnt, bcd, done} <= '0;
    end else begin
      done <= state == COMMIT;
      if (state == COMMIT) bcd <= scratch;
      if (accept) begin
        sr <= din;
        scratch <= '0;
        cnt <= '0;
      end else if (state == CONVERT) begin
        scratch <= {adj[14:0], sr[IN_WIDTH-1]};
        sr <= sr << 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
  // selected digit together with everything to its left; all-zero means a leading zero
  assign upper = bcd >> {~dspl, 2'b00};
  assign blank = blank_en && (dspl != 2'd3) && (upper == 16'h0);
  seven_seg_decoder u_dec (
    .digit (bcd[{~dspl, 2'b00} +: 4]),
    .blank (blank),
    .seg   (seg)
  );
endmodule
